// File: rtl/pll_sim_pkg.sv
// Shared types for the PLL simulation measurement blocks.
package pll_sim_pkg;

    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WAIT_REF,
        MEASURE,
        CHECK
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with a rising-edge pulse on the synced level.
module sync_edge_detect
    import pll_sim_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/phase_shift_monitor.sv
// Oversampled ref/shifted clock monitor: period, delay and sticky delay-error flag.
module phase_shift_monitor
    import pll_sim_pkg::*;
#(
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_PERIODS = 4,
    parameter int TOL_TICKS      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ref_in,
    input  logic                 shifted_in,
    input  logic                 locked,
    input  logic [CNT_WIDTH-1:0] desired_delay,
    output logic [CNT_WIDTH-1:0] period_ticks,
    output logic [CNT_WIDTH-1:0] delay_ticks,
    output logic                 meas_valid,
    output logic                 fail
);

    localparam int SW = $clog2(SETTLE_PERIODS + 1);
    localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_PERIODS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] TOL         = CNT_WIDTH'(TOL_TICKS);

    logic ref_rise;
    logic sh_rise;

    state_t               state;
    logic [SW-1:0]        settle_cnt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] delay_r;
    logic [CNT_WIDTH-1:0] period_r;
    logic                 got_delay;

    logic [CNT_WIDTH-1:0] diff;
    logic [CNT_WIDTH-1:0] alt;
    logic [CNT_WIDTH-1:0] err;
    logic                 mismatch;

    // Identical instances keep the two paths' latency matched.
    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_ref_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ref_in),
        .rise  (ref_rise)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sh_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (shifted_in),
        .rise  (sh_rise)
    );

    // Delay error taken modulo the period, so near-period delays wrap to zero.
    always_comb begin
        diff     = '0;
        alt      = '0;
        err      = '0;
        mismatch = 1'b0;
        if (delay_r >= desired_delay) begin
            diff = delay_r - desired_delay;
        end else begin
            diff = desired_delay - delay_r;
        end
        alt      = period_r - diff;
        err      = (diff <= alt) ? diff : alt;
        mismatch = !got_delay || (err > TOL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            cnt          <= '0;
            delay_r      <= '0;
            period_r     <= '0;
            got_delay    <= 1'b0;
            period_ticks <= '0;
            delay_ticks  <= '0;
            meas_valid   <= 1'b0;
            fail         <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (state != IDLE && !locked) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (locked) begin
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (ref_rise) begin
                            if (settle_cnt == SETTLE_LAST) begin
                                state <= WAIT_REF;
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end
                    end
                    WAIT_REF: begin
                        if (ref_rise) begin
                            cnt       <= '0;
                            got_delay <= sh_rise;
                            if (sh_rise) begin
                                delay_r <= '0;
                            end
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (cnt == CNT_MAX) begin
                            fail         <= 1'b1;
                            period_ticks <= CNT_MAX;
                            meas_valid   <= 1'b1;
                            state        <= WAIT_REF;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (ref_rise) begin
                                period_r <= cnt + 1'b1;
                                if (sh_rise && !got_delay) begin
                                    delay_r   <= '0;
                                    got_delay <= 1'b1;
                                end
                                state <= CHECK;
                            end else if (sh_rise && !got_delay) begin
                                delay_r   <= cnt + 1'b1;
                                got_delay <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        period_ticks <= period_r;
                        delay_ticks  <= delay_r;
                        meas_valid   <= 1'b1;
                        if (mismatch) begin
                            fail <= 1'b1;
                        end
                        state <= WAIT_REF;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/phase_shift_monitor.md
Name: phase_shift_monitor

Overview:
- Synthesizable, sample-clock-based measurement stage for the PLL simulation benches. Sits directly downstream of the PLL model outputs, in parallel with the bench's edge-timing checker.
- Oversamples a reference clock (`ref_in`) and one PLL output (`shifted_in`), then measures period and rising-edge delay in sample ticks.
- Compares the measured delay against an expected delay and reports a sticky `fail`.
- Gives a cycle-counted cross-check that does not rely on `#` delays.

Parameters:
- CNT_WIDTH, 16, width of the tick counters and the delay/period fields.
- SYNC_STAGES, 2, flop stages in each input synchronizer; must be >= 2.
- SETTLE_PERIODS, 4, number of ref rising edges ignored after `locked` rises.
- TOL_TICKS, 1, allowed absolute delay error in ticks, measured modulo the period.

Ports:
- clk  in  1  sample clock; must be faster than both monitored clocks.
- rst_n  in  1  asynchronous, active-low reset.
- ref_in  in  1  reference clock, asynchronous to clk.
- shifted_in  in  1  phase-shifted PLL output, asynchronous to clk.
- locked  in  1  PLL LOCKED; measurement runs only while high.
- desired_delay  in  CNT_WIDTH  expected ref-to-shifted delay in ticks, range 0..period-1. The bench maps negative shifts to period+shift.
- period_ticks  out  CNT_WIDTH  last measured ref period.
- delay_ticks  out  CNT_WIDTH  last measured delay.
- meas_valid  out  1  one-cycle pulse when period_ticks/delay_ticks update.
- fail  out  1  sticky mismatch/timeout flag.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, synchronizers and counters cleared.
- Input path:
  - Both inputs pass through identical SYNC_STAGES synchronizers, so their relative timing is preserved.
  - Rising-edge pulses ref_rise/sh_rise are derived from the last sync stage versus one extra registered copy.
- FSM states:
  - IDLE: wait for locked=1, then go to SETTLE with settle_cnt=0.
  - SETTLE: count ref_rise; at the SETTLE_PERIODS-th edge go to WAIT_REF.
  - WAIT_REF: on ref_rise, set cnt=0 and got_delay=0, go to MEASURE. If sh_rise occurs in the same cycle, capture delay=0 and got_delay=1.
  - MEASURE: cnt increments each cycle.
    - On sh_rise with got_delay=0: delay_r=cnt+1, got_delay=1.
    - On ref_rise: period_r=cnt+1, go to CHECK. If sh_rise coincides and got_delay=0, delay_r=0 (equivalent modulo period).
  - CHECK (one cycle):
    - Load period_ticks/delay_ticks, pulse meas_valid.
    - Evaluate the error, then return to WAIT_REF. One measurement therefore occurs every two ref periods.
- Error rule:
  - d = |delay_r − desired_delay|; err = min(d, period_r − d).
  - fail is set if err > TOL_TICKS, or if got_delay=0 (no shifted edge within the period).
  - Arithmetic is unsigned CNT_WIDTH; compute d with a compare-then-subtract.
- Timeout: if cnt reaches all-ones in MEASURE, set fail, set period_ticks to all-ones, pulse meas_valid, and go to WAIT_REF. The counter never wraps.
- locked falling in any state other than IDLE: go to IDLE next cycle, discard the partial measurement, no meas_valid. fail is retained.
- fail clears only on rst_n. Outputs hold between meas_valid pulses.
- Latency: CHECK is the cycle after the closing ref_rise, which is SYNC_STAGES+1 clk cycles after that pin edge.

Decomposition:
- Shared package `pll_sim_pkg`: FSM state enum (IDLE, SETTLE, WAIT_REF, MEASURE, CHECK) and a default CNT_WIDTH localparam.
- Sub-module `sync_edge_detect`: SYNC_STAGES synchronizer plus rising-edge pulse. Instantiated twice so both paths match exactly.

Test Plan:
- Zero shift: clk 1 ns, ref 20 ns, shifted=ref, desired_delay=0, locked after 100 ns → meas_valid pulses every 40 ns, period_ticks=20, delay_ticks=0, fail stays 0.
- 90° shift: shifted delayed 5 ns, desired_delay=5 → delay_ticks=5, fail=0. Same stimulus with desired_delay=8 → fail=1 after the first CHECK and remains 1.
- Negative shift (−45°): shifted delayed 17.5 ns, desired_delay=17, TOL_TICKS=1 → delay_ticks 17 or 18, fail=0.
- Wrap tolerance: delay 19 ticks, desired_delay=0, period 20 → err=1, fail=0. Delay 18 ticks → fail=1.
- Missing/stuck clocks: shifted_in held low → fail=1 at the first CHECK. ref_in stops while in MEASURE → fail=1 and period_ticks=0xFFFF.
- Lock loss and reset: drop locked mid-MEASURE → no meas_valid, re-SETTLE for 4 ref edges after relock, earlier fail retained. Assert rst_n=0 asynchronously → all outputs 0 immediately.
